seq_detect_prog: RTL

Runtime-programmable serial bit-pattern detector with a registered match pulse and a saturating match counter. Pattern, length (1..MAX_LEN) and overlap mode are loaded through a configuration strobe. Input bits are qualified by a valid and an enable, so the detector can sit behind a gapped serial deserialiser in the same datapath as the existing fixed-pattern detectors.

---
 rtl/seq_detect_prog_if.sv | 26 ++
 rtl/seq_detect_prog.sv | 68 ++++++
 2 files changed

// File: rtl/seq_detect_prog_if.sv
// seq_detect_prog_if: configuration, serial input and match outputs of seq_detect_prog
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  logic cfg_we_i;
  logic [MAX_LEN-1:0] cfg_pattern_i;
  logic [LEN_W-1:0] cfg_len_i;
  logic cfg_overlap_i;
  logic en_i;
  logic valid_i;
  logic x_i;
  logic cnt_clr_i;
  logic det_o;
  logic [CNT_W-1:0] count_o;
  logic cfg_err_o;
  modport master(
    output cfg_we_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i, en_i, valid_i, x_i, cnt_clr_i,
    input det_o, count_o, cfg_err_o
  );
  modport slave(
    input cfg_we_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i, en_i, valid_i, x_i, cnt_clr_i,
    output det_o, count_o, cfg_err_o
  );
endinterface

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial pattern detector with saturating match counter
module seq_detect_prog #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input logic clk,
  input logic reset,
  seq_detect_prog_if.slave bus
);
  logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d, win, mask;
  logic [LEN_W-1:0] fill_q, fill_d, len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ovl_q, ovl_d, det_q, det_d, err_q, err_d;
  logic acc, cfg_ok, hit;
  assign win = {hist_q[MAX_LEN-2:0], bus.x_i};
  assign mask = {MAX_LEN{1'b1}} >> (LEN_W'(MAX_LEN) - len_q);
  assign acc = bus.valid_i && bus.en_i && !bus.cfg_we_i;
  assign cfg_ok = bus.cfg_len_i != '0 && bus.cfg_len_i <= LEN_W'(MAX_LEN);
  assign hit = acc && fill_q >= len_q - LEN_W'(1) && ((win ^ pat_q) & mask) == '0;
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    det_d = hit;
    err_d = bus.cfg_we_i && !cfg_ok;
    cnt_d = bus.cnt_clr_i ? '0 : (hit && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    if (bus.cfg_we_i) begin
      hist_d = '0;
      fill_d = '0;
      pat_d = cfg_ok ? bus.cfg_pattern_i : pat_q;
      len_d = cfg_ok ? bus.cfg_len_i : len_q;
      ovl_d = cfg_ok ? bus.cfg_overlap_i : ovl_q;
    end else if (hit && !ovl_q) begin
      hist_d = '0;
      fill_d = '0;
    end else if (acc) begin
      hist_d = win;
      fill_d = fill_q == LEN_W'(MAX_LEN) ? fill_q : fill_q + LEN_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q <= '0;
      len_q <= LEN_W'(MAX_LEN);
      ovl_q <= 1'b1;
      det_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      det_q <= det_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.det_o = det_q;
  assign bus.count_o = cnt_q;
  assign bus.cfg_err_o = err_q;
endmodule
